// File: rtl/timer_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_sched_pkg
//  Purpose  : Shared defaults for the millisecond deadline scheduler and the
//             peripheral bus decoder that sits beside it. Defining SIM shrinks
//             the millisecond prescale to 100 cycles for simulation.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_sched_pkg;

   // Default channel geometry, shared with the bus decoder
   localparam int NUM_CH_DEF = 4;
   localparam int CH_W_DEF   = 2;
   localparam int MS_W_DEF   = 16;

   // Prescaler is a fixed 14-bit counter; 12000 cycles of a 12 MHz clock = 1 ms
   localparam int PRESC_W = 14;
`ifdef SIM
   localparam int TICKS_PER_MS_DEF = 100;
`else
   localparam int TICKS_PER_MS_DEF = 12000;
`endif

   typedef logic [PRESC_W-1:0] presc_t;

endpackage : timer_sched_pkg
`default_nettype wire

// File: rtl/timer_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : timer_sched_if
//  Purpose  : Peripheral-bus side of the deadline scheduler: arm/cancel
//             writes, interrupt acknowledge, and the IRQ/status return path.
//  Revision : 1.0 - initial release
// ============================================================================
interface timer_sched_if
   import timer_sched_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = CH_W_DEF,
   parameter int MS_W   = MS_W_DEF
);
   logic              wr_en_i;
   logic [CH_W-1:0]   wr_chan_i;
   logic [MS_W-1:0]   wr_ms_i;
   logic              wr_periodic_i;
   logic              ack_en_i;
   logic [CH_W-1:0]   ack_chan_i;
   logic              irq_o;
   logic [CH_W-1:0]   irq_chan_o;
   logic [NUM_CH-1:0] armed_o;

   // CPU / bus bridge side
   modport master (
      output wr_en_i, wr_chan_i, wr_ms_i, wr_periodic_i, ack_en_i, ack_chan_i,
      input  irq_o, irq_chan_o, armed_o
   );

   // Scheduler side
   modport slave (
      input  wr_en_i, wr_chan_i, wr_ms_i, wr_periodic_i, ack_en_i, ack_chan_i,
      output irq_o, irq_chan_o, armed_o
   );
endinterface : timer_sched_if
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ms_tick_gen
//  Purpose  : Free-running millisecond prescaler. Counts 0..TICKS_PER_MS-1
//             and raises tick_o for the single cycle spent at the top value.
//  Revision : 1.0 - initial release
// ============================================================================
module ms_tick_gen
   import timer_sched_pkg::*;
#(
   parameter int TICKS_PER_MS = TICKS_PER_MS_DEF
) (
   input  wire  clk_i,
   input  wire  rst_ni,
   output logic tick_o
);

   localparam presc_t C_TOP = presc_t'(TICKS_PER_MS - 1);

   presc_t r_count;

   // Prescaler: wraps at the top value, never restarted by bus traffic
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (r_count == C_TOP) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + presc_t'(1);
      end
   end

   assign tick_o = (r_count == C_TOP);

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : timer_sched
//  Purpose  : Multi-channel millisecond deadline scheduler. NUM_CH one-shot
//             timers share one prescaler; expiries latch pending flags that
//             merge into a single IRQ with a lowest-index-first channel ID.
//             Optional macro TIMER_SCHED_PERIODIC_EN adds auto-reload.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NUM_CH       = NUM_CH_DEF,
   parameter int CH_W         = CH_W_DEF,
   parameter int MS_W         = MS_W_DEF,
   parameter int TICKS_PER_MS = TICKS_PER_MS_DEF
) (
   input  wire           clk_i,
   input  wire           rst_ni,
   timer_sched_if.slave  bus
);

   logic              w_tick;
   logic [NUM_CH-1:0] w_armed;
   logic [NUM_CH-1:0] w_pending;
   logic [CH_W-1:0]   w_irq_chan;

   ms_tick_gen #(
      .TICKS_PER_MS (TICKS_PER_MS)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_o (w_tick)
   );

`ifndef TIMER_SCHED_PERIODIC_EN
   // One-shot build: the auto-reload request has no destination
   logic w_unused_periodic;
   assign w_unused_periodic = bus.wr_periodic_i;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic            r_armed;
      logic            r_pending;
      logic [MS_W-1:0] r_remaining;
      logic            w_wr_hit;
      logic            w_ack_hit;
      logic            w_expire;
`ifdef TIMER_SCHED_PERIODIC_EN
      logic            r_periodic;
      logic [MS_W-1:0] r_reload;
`endif

      // Out-of-range indices never match any channel, so they fall away here
      assign w_wr_hit  = bus.wr_en_i  && (bus.wr_chan_i  == CH_W'(i));
      assign w_ack_hit = bus.ack_en_i && (bus.ack_chan_i == CH_W'(i));
      assign w_expire  = w_tick && r_armed && (r_remaining == MS_W'(1));

      // Channel state: write beats tick, expiry beats ack
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_armed     <= 1'b0;
            r_pending   <= 1'b0;
            r_remaining <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
            r_periodic  <= 1'b0;
            r_reload    <= '0;
`endif
         end else if (w_wr_hit) begin
            if (bus.wr_ms_i != '0) begin
               r_armed     <= 1'b1;
               r_pending   <= 1'b0;
               r_remaining <= bus.wr_ms_i;
`ifdef TIMER_SCHED_PERIODIC_EN
               r_periodic  <= bus.wr_periodic_i;
               r_reload    <= bus.wr_ms_i;
`endif
            end else begin
               r_armed     <= 1'b0;
               r_pending   <= 1'b0;
               r_remaining <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
               r_periodic  <= 1'b0;
`endif
            end
         end else if (w_expire) begin
            r_pending <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
            if (r_periodic) begin
               r_remaining <= r_reload;
            end else begin
               r_armed     <= 1'b0;
               r_remaining <= '0;
            end
`else
            r_armed     <= 1'b0;
            r_remaining <= '0;
`endif
         end else begin
            if (w_tick && r_armed) begin
               r_remaining <= r_remaining - MS_W'(1);
            end
            if (w_ack_hit) begin
               r_pending <= 1'b0;
            end
         end
      end

      assign w_armed[i]   = r_armed;
      assign w_pending[i] = r_pending;
   end

   // Priority encoder: lowest pending index wins, 0 when nothing pending
   always_comb begin
      w_irq_chan = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_pending[k]) begin
            w_irq_chan = CH_W'(k);
         end
      end
   end

   assign bus.irq_o      = |w_pending;
   assign bus.irq_chan_o = w_irq_chan;
   assign bus.armed_o    = w_armed;

endmodule : timer_sched
`default_nettype wire

// File: tb/tb_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_sched
//  Purpose  : Self-checking bench for timer_sched with a 100-cycle millisecond.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_sched;

   localparam int T   = 100;
   localparam int NCH = 4;
`ifdef TIMER_SCHED_PERIODIC_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   timer_sched_if #(.NUM_CH(NCH), .CH_W(2), .MS_W(16)) bus ();

   timer_sched #(
      .NUM_CH(NCH), .CH_W(2), .MS_W(16), .TICKS_PER_MS(T)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: remaining ms per channel, flags, and ms phase
   int m_rem [NCH];
   bit m_armed [NCH];
   bit m_pend [NCH];
   bit m_per [NCH];
   int m_rel [NCH];
   int m_ph = 0;

   function automatic bit [6:0] exp_out();
      bit       irq = 1'b0;
      bit [1:0] ch  = 2'd0;
      bit [3:0] arm = 4'd0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (m_pend[c]) begin
            irq = 1'b1;
            ch  = 2'(c);
         end
         arm[c] = m_armed[c];
      end
      return {irq, ch, arm};
   endfunction

   task automatic model_step();
      bit tick;
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_rem[c] = 0; m_armed[c] = 0; m_pend[c] = 0; m_per[c] = 0; m_rel[c] = 0;
         end
         m_ph = 0;
      end else begin
         tick = (m_ph == T - 1);
         for (int c = 0; c < NCH; c++) begin
            if (bus.wr_en_i && int'(bus.wr_chan_i) == c) begin
               if (bus.wr_ms_i != 0) begin
                  m_rem[c] = int'(bus.wr_ms_i); m_armed[c] = 1; m_pend[c] = 0;
                  m_per[c] = PER_EN && bus.wr_periodic_i; m_rel[c] = int'(bus.wr_ms_i);
               end else begin
                  m_rem[c] = 0; m_armed[c] = 0; m_pend[c] = 0; m_per[c] = 0;
               end
            end else if (tick && m_armed[c] && m_rem[c] == 1) begin
               m_pend[c] = 1;
               if (m_per[c]) m_rem[c] = m_rel[c];
               else begin m_armed[c] = 0; m_rem[c] = 0; end
            end else begin
               if (tick && m_armed[c]) m_rem[c] = m_rem[c] - 1;
               if (bus.ack_en_i && int'(bus.ack_chan_i) == c) m_pend[c] = 0;
            end
         end
         m_ph = tick ? 0 : m_ph + 1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      bus.wr_en_i       = 1'b0;
      bus.wr_periodic_i = 1'b0;
      bus.ack_en_i      = 1'b0;
   endtask

   task automatic wr(input int ch, input int ms, input bit per);
      bus.wr_en_i = 1'b1; bus.wr_chan_i = 2'(ch); bus.wr_ms_i = 16'(ms); bus.wr_periodic_i = per;
   endtask

   task automatic ack(input int ch);
      bus.ack_en_i = 1'b1; bus.ack_chan_i = 2'(ch);
   endtask

   task automatic test_reset();
      bit [6:0] got;
      bit       exp_tick;
      rst_n = 1'b0;
      wr(1, 7, 0);
      ack(1);
      for (int k = 0; k < 3; k++) cycle();
      rst_n = 1'b1;
      got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
      checks++;
      if (got !== 7'd0) begin
         failures++; $display("FAIL reset_outputs got=%b exp=%b", got, 7'd0);
      end
      for (int k = 0; k < 250; k++) begin
         exp_tick = (m_ph == T - 1);
         checks++;
         if (dut.u_tick.tick_o !== exp_tick) begin
            failures++; $display("FAIL tick_period cyc=%0d got=%b exp=%b", k, dut.u_tick.tick_o, exp_tick);
         end
         cycle();
      end
   endtask

   task automatic test_oneshot();
      bit [6:0] got;
      int       nt = 0;
      wr(2, 3, 0);
      cycle();
      checks++;
      if (bus.armed_o !== 4'b0100) begin
         failures++; $display("FAIL oneshot_armed got=%b exp=%b", bus.armed_o, 4'b0100);
      end
      for (int k = 0; k < 400 && !bus.irq_o; k++) begin
         if (dut.u_tick.tick_o) nt++;
         cycle();
         got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
         checks++;
         if (got !== exp_out()) begin
            failures++; $display("FAIL oneshot_trace got=%b exp=%b", got, exp_out());
         end
      end
      got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
      checks++;
      if (got !== {1'b1, 2'd2, 4'b0000} || nt != 3) begin
         failures++; $display("FAIL oneshot_expiry got=%b ticks=%0d exp=%b ticks=3", got, nt, {1'b1, 2'd2, 4'b0000});
      end
      ack(2);
      cycle();
      checks++;
      if (bus.irq_o !== 1'b0) begin
         failures++; $display("FAIL oneshot_ack got=%b exp=0", bus.irq_o);
      end
   endtask

   task automatic test_priority();
      bit [6:0] got;
      for (int k = 0; k < 200 && m_ph != 0; k++) cycle();
      wr(3, 1, 0);
      cycle();
      wr(1, 1, 0);
      cycle();
      for (int k = 0; k < 200 && !bus.irq_o; k++) cycle();
      got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
      checks++;
      if (got !== {1'b1, 2'd1, 4'b0000}) begin
         failures++; $display("FAIL prio_both got=%b exp=%b", got, {1'b1, 2'd1, 4'b0000});
      end
      ack(1);
      cycle();
      got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
      checks++;
      if (got !== {1'b1, 2'd3, 4'b0000}) begin
         failures++; $display("FAIL prio_ack1 got=%b exp=%b", got, {1'b1, 2'd3, 4'b0000});
      end
      ack(3);
      cycle();
      checks++;
      if (bus.irq_o !== 1'b0) begin
         failures++; $display("FAIL prio_ack3 got=%b exp=0", bus.irq_o);
      end
   endtask

   task automatic test_collisions();
      bit [6:0] got;
      int       nt = 0;
      int       nirq = 0;
      // write lands on the tick cycle: full 5 ms still to run
      for (int k = 0; k < 200 && m_ph != T - 1; k++) cycle();
      wr(0, 5, 0);
      cycle();
      for (int k = 0; k < 700 && !bus.irq_o; k++) begin
         if (dut.u_tick.tick_o) nt++;
         cycle();
      end
      checks++;
      if (bus.irq_o !== 1'b1 || nt != 5) begin
         failures++; $display("FAIL coll_write_tick irq=%b ticks=%0d exp irq=1 ticks=5", bus.irq_o, nt);
      end
      ack(0);
      cycle();
      // ack on the expiry cycle loses to the expiry
      wr(0, 1, 0);
      cycle();
      for (int k = 0; k < 200 && m_ph != T - 1; k++) cycle();
      ack(0);
      cycle();
      got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
      checks++;
      if (got !== {1'b1, 2'd0, 4'b0000}) begin
         failures++; $display("FAIL coll_ack_expiry got=%b exp=%b", got, {1'b1, 2'd0, 4'b0000});
      end
      ack(0);
      cycle();
      checks++;
      if (bus.irq_o !== 1'b0) begin
         failures++; $display("FAIL coll_ack_clear got=%b exp=0", bus.irq_o);
      end
      // cancel mid-count
      wr(0, 3, 0);
      cycle();
      for (int k = 0; k < 50; k++) cycle();
      wr(0, 0, 0);
      cycle();
      checks++;
      if (bus.armed_o[0] !== 1'b0) begin
         failures++; $display("FAIL coll_cancel_armed got=%b exp=0", bus.armed_o[0]);
      end
      for (int k = 0; k < 400; k++) begin
         cycle();
         if (bus.irq_o) nirq++;
      end
      checks++;
      if (nirq != 0) begin
         failures++; $display("FAIL coll_cancel_irq irq_cycles=%0d exp=0", nirq);
      end
   endtask

   task automatic test_rearm();
      int nt = 0;
      wr(1, 1, 0);
      cycle();
      for (int k = 0; k < 200 && !bus.irq_o; k++) cycle();
      checks++;
      if (bus.irq_o !== 1'b1 || bus.irq_chan_o !== 2'd1) begin
         failures++; $display("FAIL rearm_first irq=%b chan=%0d exp irq=1 chan=1", bus.irq_o, bus.irq_chan_o);
      end
      wr(1, 2, 0);
      cycle();
      checks++;
      if (bus.irq_o !== 1'b0 || bus.armed_o !== 4'b0010) begin
         failures++; $display("FAIL rearm_clear irq=%b armed=%b exp irq=0 armed=0010", bus.irq_o, bus.armed_o);
      end
      for (int k = 0; k < 300 && !bus.irq_o; k++) begin
         if (dut.u_tick.tick_o) nt++;
         cycle();
      end
      checks++;
      if (bus.irq_o !== 1'b1 || nt != 2) begin
         failures++; $display("FAIL rearm_expiry irq=%b ticks=%0d exp irq=1 ticks=2", bus.irq_o, nt);
      end
      ack(1);
      cycle();
   endtask

   task automatic test_periodic();
      bit got_irq;
      bit exp_irq;
      int nirq = 0;
      wr(0, 2, 1);
      cycle();
      for (int p = 0; p < 3; p++) begin
         got_irq = 1'b0;
         for (int k = 0; k < 300 && !got_irq; k++) begin
            cycle();
            got_irq = bus.irq_o;
         end
         exp_irq = PER_EN || (p == 0);
         checks++;
         if (got_irq !== exp_irq) begin
            failures++; $display("FAIL periodic_irq%0d got=%b exp=%b", p, got_irq, exp_irq);
         end
         if (got_irq) begin
            ack(0);
            cycle();
         end
      end
      wr(0, 0, 0);
      cycle();
      for (int k = 0; k < 500; k++) begin
         cycle();
         if (bus.irq_o) nirq++;
      end
      checks++;
      if (nirq != 0 || bus.armed_o !== 4'b0000) begin
         failures++; $display("FAIL periodic_cancel irq_cycles=%0d armed=%b exp 0/0000", nirq, bus.armed_o);
      end
   endtask

   task automatic test_random();
      bit [6:0] got;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(7) == 0) wr($urandom_range(3), $urandom_range(5), 1'($urandom_range(1)));
         if ($urandom_range(5) == 0) ack($urandom_range(3));
         cycle();
         got = {bus.irq_o, bus.irq_chan_o, bus.armed_o};
         checks++;
         if (got !== exp_out()) begin
            failures++; $display("FAIL random_trace cyc=%0d got=%b exp=%b", k, got, exp_out());
         end
      end
   endtask

   initial begin
      bus.wr_en_i = 1'b0; bus.wr_chan_i = '0; bus.wr_ms_i = '0; bus.wr_periodic_i = 1'b0;
      bus.ack_en_i = 1'b0; bus.ack_chan_i = '0;
      test_reset();
      test_oneshot();
      test_priority();
      test_collisions();
      test_rearm();
      test_periodic();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_timer_sched
`default_nettype wire
